baccarat_round_ctrl: RTL

- Dealer/sequencer FSM for the baccarat datapath.
- Issues one-hot card-load strobes in dealing order P1, D1, P2, D2, then optional P3 and D3.
- Applies the natural and third-card rules using the datapath's live scores and player third card.
- Latches the winner and keeps saturating per-outcome tallies across rounds.

---
 rtl/baccarat_round_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/baccarat_round_ctrl.sv
// Baccarat dealer/sequencer.
// Deals P1, D1, P2, D2 and then an optional P3 and D3. The next card is
// chosen from the datapath's live scores and the player's third card. The
// winner is latched, and saturating tallies are kept across rounds.
//
// Ports
//   slow_clock, resetb        clock, async active-low reset
//   step                      advance qualifier (one action per cycle)
//   new_round                 restart from S_DONE
//   pscore, dscore, pcard3    live datapath scores and raw player third card
//   load_{p,d}card{1,2,3}     card-register enables (combinational)
//   clear_cards               datapath clear pulse on restart
//   player_win, dealer_win    latched result (tie: both set)
//   done                      high in S_DONE
//   round_count, *_tally      saturating counters
module baccarat_round_ctrl #(
  parameter int TALLY_W = 8
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               step,
  input  logic               new_round,
  input  logic [3:0]         pscore,
  input  logic [3:0]         dscore,
  input  logic [3:0]         pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               clear_cards,
  output logic               player_win,
  output logic               dealer_win,
  output logic               done,
  output logic [TALLY_W-1:0] round_count,
  output logic [TALLY_W-1:0] player_tally,
  output logic [TALLY_W-1:0] dealer_tally,
  output logic [TALLY_W-1:0] tie_tally
);

  typedef enum logic [3:0] {
    S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_BEVAL, S_D3, S_RESULT, S_DONE
  } state_t;

  localparam logic [TALLY_W-1:0] ONE = TALLY_W'(1);

  state_t             r_state, w_next;
  logic               r_pwin, r_dwin;
  logic [TALLY_W-1:0] r_rc, r_pt, r_dt, r_tt;
  logic [3:0]         w_v3;
  logic               w_bank_draw;
  logic               w_pge, w_dge;

  // Face cards and tens count as zero.
  assign w_v3 = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

  // Banker's third-card table, indexed by the dealer's two-card score.
  always_comb begin
    w_bank_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: w_bank_draw = 1'b1;
      4'd3:             w_bank_draw = (w_v3 != 4'd8);
      4'd4:             w_bank_draw = (w_v3 >= 4'd2) && (w_v3 <= 4'd7);
      4'd5:             w_bank_draw = (w_v3 >= 4'd4) && (w_v3 <= 4'd7);
      4'd6:             w_bank_draw = (w_v3 == 4'd6) || (w_v3 == 4'd7);
      default:          w_bank_draw = 1'b0;
    endcase
  end

  assign w_pge = (pscore >= dscore);
  assign w_dge = (dscore >= pscore);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) r_state <= S_P1;
    else         r_state <= w_next;
  end

  // Next state and outputs. Strobes are gated with resetb so they drop
  // the moment reset is asserted, even though S_P1 is the reset state.
  always_comb begin
    w_next      = r_state;
    load_pcard1 = 1'b0;
    load_dcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_dcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard3 = 1'b0;
    clear_cards = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_P1: begin
        load_pcard1 = step & resetb;
        if (step) w_next = S_D1;
      end
      S_D1: begin
        load_dcard1 = step;
        if (step) w_next = S_P2;
      end
      S_P2: begin
        load_pcard2 = step;
        if (step) w_next = S_D2;
      end
      S_D2: begin
        load_dcard2 = step;
        if (step) w_next = S_EVAL;
      end
      S_EVAL: begin
        if (step) begin
          if (pscore >= 4'd8 || dscore >= 4'd8) w_next = S_RESULT;
          else if (pscore <= 4'd5)              w_next = S_P3;
          else if (dscore <= 4'd5)              w_next = S_D3;
          else                                  w_next = S_RESULT;
        end
      end
      S_P3: begin
        load_pcard3 = step;
        if (step) w_next = S_BEVAL;
      end
      S_BEVAL: begin
        if (step) w_next = w_bank_draw ? S_D3 : S_RESULT;
      end
      S_D3: begin
        load_dcard3 = step;
        if (step) w_next = S_RESULT;
      end
      S_RESULT: w_next = S_DONE;
      S_DONE: begin
        done        = 1'b1;
        clear_cards = new_round;
        if (new_round) w_next = S_P1;
      end
      default: w_next = S_P1;
    endcase
  end

  // Result latch and saturating counters.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_pwin <= 1'b0;
      r_dwin <= 1'b0;
      r_rc   <= '0;
      r_pt   <= '0;
      r_dt   <= '0;
      r_tt   <= '0;
    end else if (r_state == S_RESULT) begin
      r_pwin <= w_pge;
      r_dwin <= w_dge;
      if (!(&r_rc)) r_rc <= r_rc + ONE;
      if (w_pge && w_dge) begin
        if (!(&r_tt)) r_tt <= r_tt + ONE;
      end else if (w_pge) begin
        if (!(&r_pt)) r_pt <= r_pt + ONE;
      end else begin
        if (!(&r_dt)) r_dt <= r_dt + ONE;
      end
    end else if (r_state == S_DONE && new_round) begin
      r_pwin <= 1'b0;
      r_dwin <= 1'b0;
    end
  end

  assign player_win   = r_pwin;
  assign dealer_win   = r_dwin;
  assign round_count  = r_rc;
  assign player_tally = r_pt;
  assign dealer_tally = r_dt;
  assign tie_tally    = r_tt;

endmodule
